// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU control codes, opcode classes, funct values and decode function
package alu_ctrl_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b0100;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLL  = 4'b1000;
  localparam logic [3:0] CTRL_SRL  = 4'b1001;
  localparam logic [3:0] CTRL_MULT = 4'b1010;
  localparam logic [3:0] CTRL_DIV  = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;

  localparam logic [1:0] OP_MEM   = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_SLTI  = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  typedef enum logic {ST_IDLE, ST_MD_BUSY} md_state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       md_op;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct);
    dec_t d;
    d = '{ctrl: CTRL_AND, illegal: 1'b0, md_op: 1'b0};
    case (alu_op)
      OP_MEM:  d.ctrl = CTRL_ADD;
      OP_BEQ:  d.ctrl = CTRL_SUB;
      OP_SLTI: d.ctrl = CTRL_SLT;
      default: begin
        case (funct)
          FN_ADD:  d.ctrl = CTRL_ADD;
          FN_SUB:  d.ctrl = CTRL_SUB;
          FN_AND:  d.ctrl = CTRL_AND;
          FN_OR:   d.ctrl = CTRL_OR;
          FN_XOR:  d.ctrl = CTRL_XOR;
          FN_NOR:  d.ctrl = CTRL_NOR;
          FN_SLT:  d.ctrl = CTRL_SLT;
          FN_SLL:  d.ctrl = CTRL_SLL;
          FN_SRL:  d.ctrl = CTRL_SRL;
          FN_MULT: begin d.ctrl = CTRL_MULT; d.md_op = 1'b1; end
          FN_DIV:  begin d.ctrl = CTRL_DIV;  d.md_op = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_control_seq_md_seq.sv
// rtl/alu_control_seq_md_seq.sv - MULT/DIV busy sequencer: start pulse, latency counter, done pulse
module md_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  output logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] LAST          = CNT_W'(MD_CYCLES - 1);
  localparam logic             FIRST_IS_LAST = (MD_CYCLES == 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Outputs are computed one cycle ahead so they can be registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      md_start <= 1'b0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
    end else begin
      md_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_MD_BUSY;
            cnt      <= '0;
            md_start <= 1'b1;
            md_busy  <= 1'b1;
            md_done  <= FIRST_IS_LAST;
          end
        end
        ST_MD_BUSY: begin
          if (cnt == LAST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
          end else begin
            cnt     <= CNT_W'(cnt + 1'b1);
            md_done <= (CNT_W'(cnt + 1'b1) == LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - ALU control decode with registered valid/ready output and MULT/DIV sequencing
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               illegal,
  output logic               md_op,
  output logic               md_start,
  output logic               md_busy,
  output logic               md_done
);

  logic [5:0] funct6;
  dec_t       dec;
  logic       accept;

  assign funct6   = 6'(funct);
  assign dec      = decode(alu_op, funct6);
  assign in_ready = !md_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Result register holds its value under back-pressure; only out_valid drops on a bare transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      illegal   <= 1'b0;
      md_op     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl      <= CTRL_W'(dec.ctrl);
      illegal   <= dec.illegal;
      md_op     <= dec.md_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  md_seq #(
    .MD_CYCLES(MD_CYCLES),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .reset   (reset),
    .launch  (accept && dec.md_op),
    .md_start(md_start),
    .md_busy (md_busy),
    .md_done (md_done)
  );

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Next-generation ALU control unit for the MIPS datapath.
- Decodes a 2-bit ALU operation class plus the R-type funct field into the ALU control code, and registers the result behind a valid/ready handshake.
- Adds multi-cycle sequencing for MULT/DIV: it asserts a start pulse, counts the operation's latency, and back-pressures the decode stage until the operation is done.
- Sits between the main control/decode stage and the ALU/muldiv unit.

Parameters:
- FUNCT_W, 6, width of the funct field.
- CTRL_W, 4, width of the ALU control code (must be at least 4).
- MD_CYCLES, 32, number of busy cycles for MULT/DIV (must be at least 1).
- CNT_W, $clog2(MD_CYCLES+1), width of the busy counter (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage presents an operation.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  2  operation class: 00 lw/sw, 01 beq, 10 R-type, 11 slti.
- funct  in  FUNCT_W  R-type funct field; used only when alu_op=10.
- out_valid  out  1  ctrl/illegal/md_op hold a registered result.
- out_ready  in  1  ALU side consumes the result.
- ctrl  out  CTRL_W  ALU control code.
- illegal  out  1  unknown funct was decoded.
- md_op  out  1  current result is MULT or DIV.
- md_start  out  1  one-cycle pulse that launches the muldiv unit.
- md_busy  out  1  a multi-cycle operation is in progress.
- md_done  out  1  one-cycle pulse in the last busy cycle.

Behaviour:
- Control code encoding (shared package): AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0100, SLT 0111, SLL 1000, SRL 1001, MULT 1010, DIV 1011, NOR 1100.
- alu_op mapping:
  - 00 → ADD.
  - 01 → SUB.
  - 11 → SLT.
  - 10 → funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL, 011000 MULT, 011010 DIV.
  - Any other funct → ctrl=0000 (AND), illegal=1, md_op=0.
- Decode is combinational; all outputs are registered.
- Handshake:
  - in_ready = !md_busy && (!out_valid || out_ready).
  - An operation is accepted when in_valid && in_ready.
  - An operation accepted in cycle N appears with out_valid=1 in cycle N+1.
  - A result transfers when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, ctrl/illegal/md_op stay stable.
  - A transfer and a new accept in the same cycle give back-to-back results with no bubble.
  - A transfer with no new accept clears out_valid next cycle.
- FSM with states IDLE and MD_BUSY:
  - IDLE → MD_BUSY when the accepted operation is MULT or DIV.
  - In cycle N+1: md_start=1 for exactly one cycle, md_busy=1, cnt=0.
  - In MD_BUSY, cnt increments each cycle.
  - When cnt==MD_CYCLES-1: md_done=1 in that cycle; next state is IDLE and md_busy=0.
  - md_busy is therefore high for exactly MD_CYCLES cycles (N+1 .. N+MD_CYCLES).
  - With MD_CYCLES=1, md_start and md_done are high in the same cycle.
- Busy behaviour:
  - The counter runs whether or not the MULT/DIV result beat has been transferred.
  - in_ready stays 0 throughout MD_BUSY, so in_valid is ignored there.
  - The first post-busy accept can occur in cycle N+MD_CYCLES+1.
- Counter width: no wrap; the counter is cleared on entry to MD_BUSY.
- Reset:
  - out_valid, ctrl, illegal, md_op, md_start, md_busy, md_done = 0.
  - State = IDLE, cnt = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-MULT/DIV aborts immediately: no md_done is emitted.
- Reset has priority over every other event in the same cycle.

Decomposition:
- Package alu_ctrl_pkg:
  - ctrl code constants.
  - alu_op class constants.
  - funct constants.
  - FSM state typedef.
  - pure decode function returning {ctrl, illegal, md_op}.
- Sub-module md_seq: FSM, counter, md_start/md_busy/md_done.
- Top-level module: decode plus output register and handshake.

Test Plan:
- Reset, then idle → all outputs 0 and in_ready=1; assert reset mid-DIV at busy cycle 5 → md_busy=0 next cycle and no md_done.
- Back-to-back with out_ready=1:
  - alu_op=00, then 01, then 10/100101 (OR), then 11 → ctrl 0010, 0100, 0001, 0111 on four consecutive cycles.
- Illegal funct: alu_op=10, funct=111111 → ctrl=0000 and illegal=1 for one beat; the next legal op clears illegal.
- Back-pressure: out_ready=0 for 3 cycles after an ADD beat → ctrl=0010 held, in_ready=0; out_ready=1 with a SUB accepted the same cycle → ctrl=0100 next cycle.
- MULT with MD_CYCLES=4, accepted at cycle 10:
  - md_start at 11 only; md_busy 11–14; md_done at 14.
  - in_ready=0 during 11–14; the next op is accepted at 15.
- DIV with MD_CYCLES=1 → md_start, md_busy and md_done all high in the single cycle after accept; in_ready returns the following cycle.
